mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single main-memory port between I-cache refills and D-cache refills/writebacks.
//  Models the fixed memory latency itself with a down-counter.
//  Returns one-cycle acks whose timing drives the cache miss signals seen by stall_control.
//  Sits between the caches and the memory array; drops I-side fills killed by a branch flush.
// PARAMETERS
//  ADDR_W       32   line-aligned byte address width
//  LINE_W       128  cache line width (bits), one memory transfer
//  MEM_LATENCY  5    cycles a transfer occupies the port (>=1)
//  STARVE_MAX   4    consecutive D-side grants with ic_req pending before I-side is forced
// PORTS
//  clk           in   1       clock, rising edge
//  reset         in   1       asynchronous, active-low reset
//  ic_req        in   1       I-cache line fill request, held until ic_ack
//  ic_addr       in   ADDR_W  I-cache fill address
//  ic_flush      in   1       branch flush: kill pending/in-flight I-side fill
//  ic_ack        out  1       1-cycle pulse: ic_rdata valid
//  ic_rdata      out  LINE_W  fill data for I-cache
//  dc_req        in   1       D-cache line fill request, held until dc_ack
//  dc_addr       in   ADDR_W  D-cache fill address
//  dc_wb_req     in   1       D-cache dirty writeback request, held until dc_wb_ack
//  dc_wb_addr    in   ADDR_W  writeback address
//  dc_wb_data    in   LINE_W  writeback line
//  dc_ack        out  1       1-cycle pulse: dc_rdata valid
//  dc_wb_ack     out  1       1-cycle pulse: writeback committed
//  dc_rdata      out  LINE_W  fill data for D-cache
//  mem_addr      out  ADDR_W  address to memory array (async read)
//  mem_we        out  1       1-cycle line write strobe
//  mem_wdata     out  LINE_W  write data
//  mem_rdata     in   LINE_W  async read data for mem_addr
//  mem_busy      out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, starve=0, drop=0.
//  Reset: all acks=0, mem_we=0, rdata/addr/wdata regs=0.
//  Reset mid-transfer discards it; no memory write occurs.
//  FSM states: IDLE, WB, DFILL, IFILL; cnt loaded MEM_LATENCY-1 on entry; decrements each cycle in service.
//  IDLE grant priority, evaluated at the edge:
//   (1) dc_wb_req->WB;
//   (2) dc_req->DFILL;
//   (3) ic_req && !ic_flush->IFILL.
//  Starvation override: if starve==STARVE_MAX and ic_req && !ic_flush, IFILL wins over (1)/(2).
//  Address/data latch on grant; requester inputs are ignored until ack.
//  starve: +1 (saturating) on each D-side grant while ic_req=1; cleared on IFILL grant or when ic_req=0.
//  Port occupancy: a grant at edge t0 keeps the state in service for cycles t0+1..t0+MEM_LATENCY.
//  mem_addr = latched address.
//  WB, cnt==0: mem_we=1, mem_wdata=latched line (only cycle mem_we is ever 1).
//  WB, cnt==0: dc_wb_ack=1 next cycle.
//  WB, cnt==0: next state DFILL if dc_req, else IDLE (DFILL chaining skips IDLE).
//  DFILL, cnt==0: dc_rdata<=mem_rdata; dc_ack=1 next cycle; ->IDLE.
//  IFILL, cnt==0: ic_rdata<=mem_rdata; ic_ack=1 next cycle unless drop; ->IDLE; drop cleared.
//  Latency: ack in cycle t0+MEM_LATENCY+1. Acks are registered 1-cycle pulses; never two acks in one cycle.
//  Ack cycle: the acked requester's req is ignored for grant (it drops its req that cycle).
//  ic_flush during IFILL sets drop; the transfer still completes (port cannot abort).
//  ic_flush in IDLE blocks the I grant that cycle only.
//  ic_flush and completion in the same cycle: ack suppressed.
//  Simultaneous dc_wb_req and dc_req: WB first, then chained DFILL.
//  mem_addr holds its last value in IDLE; mem_wdata is don't-care outside WB.
// TESTING
//  ML=5. dc_req@A=0x40 at cycle 0 -> mem_busy cycles 1-5; dc_ack=1 and dc_rdata=mem[0x40] at cycle 6 only.
//  dc_wb_req(0x80,D) + dc_req(0x40) at cycle 0 -> mem_we=1 @0x80 cycle 5, dc_wb_ack cycle 6.
//   -> same case: DFILL cycles 6-10, dc_ack cycle 11.
//  ic_req and dc_req both at cycle 0 -> D granted first; ic_ack cycle 12 (IFILL cycles 7-11 after dc_ack gap).
//  IFILL in flight, ic_flush pulse cycle 3 -> no ic_ack ever.
//   -> next ic_req (new addr) granted at the following IDLE with fresh address.
//  dc_req held continuously re-asserted + ic_req held, STARVE_MAX=4 -> 5th grant goes to IFILL; starve resets to 0.
//  reset low during WB at cycle 3 -> mem_we never pulses, all outputs 0.
//   -> after release, the still-held dc_wb_req is re-granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single main-memory port between I-cache fills and
// D-cache fills/writebacks, modelling fixed memory latency with a counter.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 128,
    parameter int MEM_LATENCY = 5,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_flush,
    output logic              ic_ack,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_wb_req,
    input  logic [ADDR_W-1:0] dc_wb_addr,
    input  logic [LINE_W-1:0] dc_wb_data,
    output logic              dc_ack,
    output logic              dc_wb_ack,
    output logic [LINE_W-1:0] dc_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              mem_busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WB    = 2'd1;
    localparam logic [1:0] DFILL = 2'd2;
    localparam logic [1:0] IFILL = 2'd3;

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LATENCY - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     starve;
    logic              drop;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic ic_pend;
    logic ic_live;
    logic dc_live;
    logic wb_live;
    logic done;
    logic starved;
    logic chain_dc;
    logic d_grant;
    logic grant_wb;
    logic grant_dc;
    logic grant_ic;

    // A requester that is being acked this cycle is dropping its request.
    assign ic_pend  = ic_req && !ic_ack;
    assign ic_live  = ic_pend && !ic_flush;
    assign dc_live  = dc_req && !dc_ack;
    assign wb_live  = dc_wb_req && !dc_wb_ack;
    assign done     = (cnt == '0);
    assign starved  = (starve == STARVE_TOP);
    assign chain_dc = (state == WB) && done && dc_req;
    assign d_grant  = grant_wb || grant_dc || chain_dc;

    always_comb begin
        grant_wb = 1'b0;
        grant_dc = 1'b0;
        grant_ic = 1'b0;
        if (state == IDLE) begin
            if (ic_live && starved) begin
                grant_ic = 1'b1;
            end else if (wb_live) begin
                grant_wb = 1'b1;
            end else if (dc_live) begin
                grant_dc = 1'b1;
            end else if (ic_live) begin
                grant_ic = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            starve    <= '0;
            drop      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ic_ack    <= 1'b0;
            dc_ack    <= 1'b0;
            dc_wb_ack <= 1'b0;
            ic_rdata  <= '0;
            dc_rdata  <= '0;
        end else begin
            ic_ack    <= 1'b0;
            dc_ack    <= 1'b0;
            dc_wb_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ic) begin
                        state  <= IFILL;
                        cnt    <= CNT_LOAD;
                        addr_q <= ic_addr;
                    end else if (grant_wb) begin
                        state   <= WB;
                        cnt     <= CNT_LOAD;
                        addr_q  <= dc_wb_addr;
                        wdata_q <= dc_wb_data;
                    end else if (grant_dc) begin
                        state  <= DFILL;
                        cnt    <= CNT_LOAD;
                        addr_q <= dc_addr;
                    end
                end
                WB: begin
                    if (done) begin
                        dc_wb_ack <= 1'b1;
                        if (dc_req) begin
                            state  <= DFILL;
                            cnt    <= CNT_LOAD;
                            addr_q <= dc_addr;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DFILL: begin
                    if (done) begin
                        dc_rdata <= mem_rdata;
                        dc_ack   <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    // The port cannot abort, so a flushed fill runs to completion silently.
                    if (done) begin
                        ic_rdata <= mem_rdata;
                        ic_ack   <= !(drop || ic_flush);
                        drop     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (ic_flush) begin
                            drop <= 1'b1;
                        end
                    end
                end
            endcase

            if (!ic_pend || grant_ic) begin
                starve <= '0;
            end else if (d_grant && !starved) begin
                starve <= starve + 1'b1;
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = (state == WB) && done;
    assign mem_busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing scenarios plus random
// traffic checked by a scoreboard against a reference memory.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int ML = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_req;
    logic [AW-1:0] ic_addr;
    logic          ic_flush;
    logic          ic_ack;
    logic [LW-1:0] ic_rdata;
    logic          dc_req;
    logic [AW-1:0] dc_addr;
    logic          dc_wb_req;
    logic [AW-1:0] dc_wb_addr;
    logic [LW-1:0] dc_wb_data;
    logic          dc_ack;
    logic          dc_wb_ack;
    logic [LW-1:0] dc_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .LINE_W(LW), .MEM_LATENCY(ML), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_flush(ic_flush),
        .ic_ack(ic_ack), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_addr(dc_addr),
        .dc_wb_req(dc_wb_req), .dc_wb_addr(dc_wb_addr),
        .dc_wb_data(dc_wb_data),
        .dc_ack(dc_ack), .dc_wb_ack(dc_wb_ack), .dc_rdata(dc_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        int            t;
    } txn_t;

    txn_t ic_q[$];
    txn_t dc_q[$];
    txn_t wb_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [LW-1:0] mem_arr[16];
    bit   [15:0]   mem_vld;
    logic [LW-1:0] ref_mem[16];
    bit   [15:0]   ref_vld;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] init_pat(int i);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(i) * 32'h00010101;
        return {w, ~w, w ^ 32'h5A5A5A5A, w + 32'd7};
    endfunction

    function automatic logic [AW-1:0] addr_of(int idx);
        return {24'h0, idx[3:0], 4'h0};
    endfunction

    function automatic logic [LW-1:0] ref_read(logic [AW-1:0] a);
        logic [3:0] i;
        i = a[7:4];
        return ref_vld[i] ? ref_mem[i] : init_pat(int'(i));
    endfunction

    // Memory array: async read, line write on mem_we.
    assign mem_rdata = mem_vld[mem_addr[7:4]] ? mem_arr[mem_addr[7:4]]
                                              : init_pat(int'(mem_addr[7:4]));

    always @(posedge clk) begin
        if (mem_we) begin
            mem_arr[mem_addr[7:4]] <= mem_wdata;
            mem_vld[mem_addr[7:4]] <= 1'b1;
        end
    end

    task automatic check1(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check32(string name, logic [AW-1:0] act,
                           logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkw(string name, logic [LW-1:0] act,
                          logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic issue_ic(int idx);
        txn_t x;
        ic_req  = 1'b1;
        ic_addr = addr_of(idx);
        x = '{addr: ic_addr, data: '0, t: cyc};
        ic_q.push_back(x);
    endtask

    task automatic issue_dc(int idx);
        txn_t x;
        dc_req  = 1'b1;
        dc_addr = addr_of(idx);
        x = '{addr: dc_addr, data: '0, t: cyc};
        dc_q.push_back(x);
    endtask

    task automatic issue_wb(int idx, logic [LW-1:0] d);
        txn_t x;
        dc_wb_req  = 1'b1;
        dc_wb_addr = addr_of(idx);
        dc_wb_data = d;
        x = '{addr: dc_wb_addr, data: d, t: cyc};
        wb_q.push_back(x);
    endtask

    // A flush kills the outstanding fill; the I-cache re-requests elsewhere.
    task automatic flush_ic(int idx);
        txn_t x;
        ic_flush = 1'b1;
        ic_addr  = addr_of(idx);
        void'(ic_q.pop_back());
        x = '{addr: ic_addr, data: '0, t: cyc};
        ic_q.push_back(x);
    endtask

    task automatic tick();
        @(negedge clk);
        ic_flush = 1'b0;
        if (ic_ack) ic_req = 1'b0;
        if (dc_ack) dc_req = 1'b0;
        if (dc_wb_ack) dc_wb_req = 1'b0;
    endtask

    task automatic drain(string tn);
        int w;
        w = 0;
        while ((ic_q.size() + dc_q.size() + wb_q.size()) != 0 && w < 300) begin
            tick();
            w++;
        end
        check1({tn, " drained"},
               (ic_q.size() + dc_q.size() + wb_q.size()) == 0, 1'b1);
    endtask

    task automatic run_expect(string tn, int n, int we_c, int wb_c,
                              int dc_c, int ic_c, int b1l, int b1h,
                              int b2l, int b2h, int fl_k, int fl_idx,
                              int rst_k);
        for (int k = 1; k <= n; k++) begin
            string s;
            tick();
            s = $sformatf("%s c%0d", tn, k);
            check1({s, " busy"}, mem_busy,
                   (k >= b1l && k <= b1h) || (k >= b2l && k <= b2h));
            check1({s, " we"}, mem_we, k == we_c);
            check1({s, " wb_ack"}, dc_wb_ack, k == wb_c);
            check1({s, " dc_ack"}, dc_ack, k == dc_c);
            check1({s, " ic_ack"}, ic_ack, k == ic_c);
            if (!reset) begin
                check32({s, " rst addr"}, mem_addr, '0);
                checkw({s, " rst wdata"}, mem_wdata, '0);
                checkw({s, " rst dc_rdata"}, dc_rdata, '0);
                checkw({s, " rst ic_rdata"}, ic_rdata, '0);
            end
            if (k == fl_k) flush_ic(fl_idx);
            if (k == rst_k) reset = 1'b0;
            if (k == rst_k + 2) reset = 1'b1;
        end
    endtask

    // Scoreboard monitor, sampled well clear of the active edge.
    initial begin
        txn_t tx;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                if (ic_ack || dc_ack || dc_wb_ack)
                    check1("ack onehot", $onehot({ic_ack, dc_ack, dc_wb_ack}), 1'b1);
                if (mem_we) begin
                    check1("write expected", wb_q.size() > 0, 1'b1);
                    if (wb_q.size() > 0) begin
                        check32("write addr", mem_addr, wb_q[0].addr);
                        checkw("write data", mem_wdata, wb_q[0].data);
                    end
                end
                if (dc_wb_ack) begin
                    check1("wb ack expected", wb_q.size() > 0, 1'b1);
                    if (wb_q.size() > 0) begin
                        tx = wb_q.pop_front();
                        check1("wb latency", (cyc - tx.t) >= ML + 1, 1'b1);
                        ref_mem[tx.addr[7:4]] = tx.data;
                        ref_vld[tx.addr[7:4]] = 1'b1;
                    end
                end
                if (dc_ack) begin
                    check1("dc ack expected", dc_q.size() > 0, 1'b1);
                    if (dc_q.size() > 0) begin
                        tx = dc_q.pop_front();
                        check1("dc latency", (cyc - tx.t) >= ML + 1, 1'b1);
                        checkw("dc_rdata", dc_rdata, ref_read(tx.addr));
                    end
                end
                if (ic_ack) begin
                    check1("ic ack expected", ic_q.size() > 0, 1'b1);
                    if (ic_q.size() > 0) begin
                        tx = ic_q.pop_front();
                        check1("ic latency", (cyc - tx.t) >= ML + 1, 1'b1);
                        checkw("ic_rdata", ic_rdata, ref_read(tx.addr));
                    end
                end
            end
        end
    end

    initial begin
        reset      = 1'b0;
        ic_req     = 1'b0;
        ic_addr    = '0;
        ic_flush   = 1'b0;
        dc_req     = 1'b0;
        dc_addr    = '0;
        dc_wb_req  = 1'b0;
        dc_wb_addr = '0;
        dc_wb_data = '0;
        repeat (3) @(negedge clk);
        check1("reset busy", mem_busy, 1'b0);
        check1("reset we", mem_we, 1'b0);
        check1("reset acks", ic_ack | dc_ack | dc_wb_ack, 1'b0);
        check32("reset addr", mem_addr, '0);
        checkw("reset dc_rdata", dc_rdata, '0);
        checkw("reset ic_rdata", ic_rdata, '0);
        reset = 1'b1;
        tick();

        // Single D fill.
        issue_dc(4);
        run_expect("t1", 8, -1, -1, 6, -1, 1, 5, 0, -1, -1, 0, -1);
        drain("t1");

        // Writeback and fill together: WB then chained DFILL.
        tick();
        issue_wb(8, rnd_line());
        issue_dc(4);
        run_expect("t2", 12, 5, 6, 11, -1, 1, 10, 0, -1, -1, 0, -1);
        drain("t2");

        // I and D together: D first, I after the ack gap.
        tick();
        issue_ic(2);
        issue_dc(9);
        run_expect("t3", 13, -1, -1, 6, 12, 1, 5, 7, 11, -1, 0, -1);
        drain("t3");

        // Flush during IFILL: old fill silent, new address served next.
        tick();
        issue_ic(1);
        run_expect("t4", 13, -1, -1, -1, 12, 1, 5, 7, 11, 3, 3, -1);
        drain("t4");

        // Starvation: D side keeps the port busy until the I side is forced.
        tick();
        issue_wb(5, rnd_line());
        issue_dc(6);
        issue_ic(7);
        for (int k = 1; k <= 34; k++) begin
            string s;
            tick();
            s = $sformatf("t5 c%0d", k);
            check1({s, " ic_ack"}, ic_ack, k == 28);
            check1({s, " wb_ack"}, dc_wb_ack, k == 6 || k == 17 || k == 34);
            check1({s, " dc_ack"}, dc_ack, k == 11 || k == 22);
            if (k < 24) begin
                if (!dc_req && !dc_ack) issue_dc(6);
                if (!dc_wb_req && !dc_wb_ack) issue_wb(5, rnd_line());
            end
        end
        drain("t5");

        // Reset in the middle of a writeback; held request is re-granted.
        tick();
        issue_wb(8, rnd_line());
        run_expect("t6", 12, 10, 11, -1, -1, 1, 3, 6, 10, -1, 0, 3);
        drain("t6");

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            tick();
            if (!ic_req && !ic_ack) begin
                if ($urandom_range(3) == 0) issue_ic(int'($urandom_range(15)));
            end else if (ic_req && !ic_ack && $urandom_range(29) == 0) begin
                flush_ic(int'($urandom_range(15)));
            end
            if (!dc_req && !dc_ack && $urandom_range(2) == 0)
                issue_dc(int'($urandom_range(15)));
            if (!dc_wb_req && !dc_wb_ack && $urandom_range(4) == 0)
                issue_wb(int'($urandom_range(15)), rnd_line());
        end
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
